l1_ahb_mtx_arb_rr: RTL



---
 rtl/l1_ahb_mtx_arb_rr.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/l1_ahb_mtx_arb_rr.sv
// Round-robin output-stage arbiter for one slave port of the L1 AHB bus matrix.
// Optional INCR hold limit enabled by defining L1_AHB_ARB_INCR_LIMIT_EN.
module l1_ahb_mtx_arb_rr #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned MAX_HOLD  = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [1:0]           addr_in_port,
    output logic                 no_port,
    output logic                 arb_hold
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransBusy   = 2'b01;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;
    localparam logic [2:0] BurstIncr   = 3'b001;

    if (NUM_PORTS < 2 || NUM_PORTS > 4) begin : gen_bad_num_ports
        $error("NUM_PORTS must be in 2..4");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : gen_bad_max_hold
        $error("MAX_HOLD must be in 2..255");
    end

    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic [1:0] addr_q, addr_d;
    logic [1:0] last_grant_q, last_grant_d;
    logic       no_port_q, no_port_d;
    logic       arb_hold_q, arb_hold_d;

    logic [3:0] req_pad;
    logic       rr_found;
    logic [1:0] rr_win;
    logic [2:0] rr_sum;
    logic       keep_owner;
    logic       incr_hold;
    logic       incr_ok;

    always_comb begin
        req_pad = '0;
        req_pad[NUM_PORTS-1:0] = req_port;
    end

    // Beat counter: remaining SEQ beats of a fixed-length burst.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        case (HTRANSM)
            TransNonseq: begin
                beat_cnt_d = 4'd0;
                if (HSELM) begin
                    case (HBURSTM)
                        3'b010, 3'b011: beat_cnt_d = 4'd3;
                        3'b100, 3'b101: beat_cnt_d = 4'd7;
                        3'b110, 3'b111: beat_cnt_d = 4'd15;
                        default:        beat_cnt_d = 4'd0;
                    endcase
                end
            end
            TransSeq: begin
                if (beat_cnt_q != 4'd0) beat_cnt_d = beat_cnt_q - 4'd1;
            end
            TransBusy: beat_cnt_d = beat_cnt_q;
            default:   beat_cnt_d = 4'd0;
        endcase
    end

    // Scan starts after the last winner, so the current owner waits its turn.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        rr_sum   = '0;
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            rr_sum = {1'b0, last_grant_q} + 3'(i);
            if (rr_sum >= 3'(NUM_PORTS)) rr_sum = rr_sum - 3'(NUM_PORTS);
            if (!rr_found && req_pad[rr_sum[1:0]]) begin
                rr_found = 1'b1;
                rr_win   = rr_sum[1:0];
            end
        end
    end

    assign keep_owner = HMASTLOCKM || (beat_cnt_d != 4'd0);
    assign incr_hold  = (HBURSTM == BurstIncr) && (HTRANSM != TransIdle) && req_pad[addr_q];

`ifdef L1_AHB_ARB_INCR_LIMIT_EN
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [3:0] others;
    logic       limit_hit;

    always_comb begin
        others         = req_pad;
        others[addr_q] = 1'b0;
        limit_hit      = (hold_cnt_q == 8'(MAX_HOLD - 1)) && (|others);
    end

    assign incr_ok = incr_hold && !limit_hit;

    always_comb begin
        hold_cnt_d = 8'd0;
        if (!keep_owner && incr_ok) hold_cnt_d = hold_cnt_q + 8'd1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_cnt_q <= 8'd0;
        end else if (HREADYM) begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign incr_ok = incr_hold;
`endif

    always_comb begin
        addr_d       = addr_q;
        no_port_d    = no_port_q;
        last_grant_d = last_grant_q;
        arb_hold_d   = (beat_cnt_d != 4'd0);
        if (!keep_owner) begin
            if (incr_ok) begin
                no_port_d = 1'b0;
            end else if (rr_found) begin
                addr_d       = rr_win;
                last_grant_d = rr_win;
                no_port_d    = 1'b0;
            end else if (HSELM) begin
                no_port_d = 1'b0;
            end else begin
                no_port_d = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            beat_cnt_q   <= 4'd0;
            addr_q       <= 2'd0;
            last_grant_q <= 2'(NUM_PORTS - 1);
            no_port_q    <= 1'b1;
            arb_hold_q   <= 1'b0;
        end else if (HREADYM) begin
            beat_cnt_q   <= beat_cnt_d;
            addr_q       <= addr_d;
            last_grant_q <= last_grant_d;
            no_port_q    <= no_port_d;
            arb_hold_q   <= arb_hold_d;
        end
    end

    assign addr_in_port = addr_q;
    assign no_port      = no_port_q;
    assign arb_hold     = arb_hold_q;

endmodule
